// File: rtl/wb_dma_copy.sv
// Wishbone word-copy engine: a slave register window programs SRC/DST/LEN and a
// master port copies LEN 32-bit words with one idle cycle between bus cycles.
module wb_dma_copy #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WGAP, S_WR, S_RGAP} state_t;

  localparam logic [2:0]  REG_SRC    = 3'd0;
  localparam logic [2:0]  REG_DST    = 3'd1;
  localparam logic [2:0]  REG_LEN    = 3'd2;
  localparam logic [2:0]  REG_CTRL   = 3'd3;
  localparam logic [2:0]  REG_STATUS = 3'd4;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] src_q, dst_q, data_q;
  logic [15:0] len_q, rem_q, tcnt_q;
  logic        ien_q, done_q, err_q;

  logic        busy, active, timeout, wb_hit, wb_wr, start;
  logic [2:0]  reg_sel;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign m_sel_o = 4'hF;
  assign irq     = ien_q & (done_q | err_q);

  assign busy    = (state_q != S_IDLE);
  assign active  = (state_q == S_RD) || (state_q == S_WR);
  assign timeout = active & ~m_ack_i & (tcnt_q == TIMEOUT_LAST);
  assign reg_sel = wb_adr_i[4:2];
  assign wb_hit  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wb_wr   = wb_hit & wb_we_i;
  assign start   = wb_wr & (reg_sel == REG_CTRL) & wb_dat_i[0] & ~busy;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rd_data = 32'd0;
    case (reg_sel)
      REG_SRC:    rd_data = src_q;
      REG_DST:    rd_data = dst_q;
      REG_LEN:    rd_data = {16'd0, len_q};
      REG_CTRL:   rd_data = {30'd0, ien_q, 1'b0};
      REG_STATUS: rd_data = {rem_q, 13'd0, err_q, done_q, busy};
      default:    rd_data = 32'd0;
    endcase
    case (state_q)
      S_IDLE: if (start && len_q != 16'd0) state_d = S_RD;
      S_RD:   if (m_ack_i) state_d = S_WGAP;
              else if (timeout) state_d = S_IDLE;
      S_WGAP: state_d = S_WR;
      S_WR:   if (m_ack_i) state_d = (rem_q == 16'd1) ? S_IDLE : S_RGAP;
              else if (timeout) state_d = S_IDLE;
      S_RGAP: state_d = S_RD;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= 16'd0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= 32'd0;
      m_dat_o <= 32'd0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= active ? tcnt_q + 16'd1 : 16'd0;
      m_cyc_o <= (state_d == S_RD) || (state_d == S_WR);
      m_stb_o <= (state_d == S_RD) || (state_d == S_WR);
      m_we_o  <= (state_d == S_WR);
      // Address and data only load on strobe cycles, so they hold for the whole strobe.
      if (state_d == S_RD) m_adr_o <= src_q;
      if (state_d == S_WR) begin
        m_adr_o <= dst_q;
        m_dat_o <= data_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      len_q    <= 16'd0;
      rem_q    <= 16'd0;
      data_q   <= 32'd0;
      ien_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wb_ack_o <= wb_hit;
      wb_dat_o <= (wb_hit && !wb_we_i) ? rd_data : 32'd0;

      if (wb_wr) begin
        case (reg_sel)
          REG_SRC: if (!busy) src_q <= {wb_dat_i[31:2], 2'b00};
          REG_DST: if (!busy) dst_q <= {wb_dat_i[31:2], 2'b00};
          REG_LEN: if (!busy) len_q <= wb_dat_i[15:0];
          REG_CTRL: begin
            ien_q <= wb_dat_i[1];
            if (start) begin
              if (len_q == 16'd0) begin
                done_q <= 1'b1;
              end else begin
                rem_q  <= len_q;
                done_q <= 1'b0;
                err_q  <= 1'b0;
              end
            end
          end
          REG_STATUS: begin
            if (wb_dat_i[1]) done_q <= 1'b0;
            if (wb_dat_i[2]) err_q  <= 1'b0;
          end
          default: ;
        endcase
      end

      // Engine updates come last so completion or error wins over a same-edge W1C.
      if (state_q == S_RD && m_ack_i) data_q <= m_dat_i;
      if (state_q == S_WR && m_ack_i) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        rem_q <= rem_q - 16'd1;
        if (rem_q == 16'd1) done_q <= 1'b1;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy: a pattern-returning memory model on the master
// port with configurable wait states, and register accesses on the slave port.
module tb_wb_dma_copy;

  localparam int TO = 15;
  localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08,
                          A_CTRL = 32'h0C, A_STAT = 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_dma_copy #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i), .irq(irq)
  );

  // Memory model: read data is a fixed function of the address.
  int wait_n = 0;
  bit never_ack = 1'b0;
  int wcnt = 0;
  int cyc_cnt = 0;
  logic [31:0] rd_q[$], wa_q[$], wd_q[$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign m_ack_i = m_cyc_o && m_stb_o && !never_ack && (wcnt >= wait_n);
  assign m_dat_i = pat(m_adr_o);

  always @(posedge clk) begin
    wcnt <= (m_stb_o && !m_ack_i) ? wcnt + 1 : 0;
    if (m_cyc_o) cyc_cnt <= cyc_cnt + 1;
    if (m_cyc_o && m_stb_o && m_ack_i) begin
      if (m_we_o) begin
        wa_q.push_back(m_adr_o);
        wd_q.push_back(m_dat_o);
      end else begin
        rd_q.push_back(m_adr_o);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    bit ok = 1'b0;
    rdat = 32'd0;
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        ok = 1'b1;
        rdat = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!ok) check("slave_ack_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_access(adr, 1'b1, dat, dummy);
  endtask

  task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    wb_access(adr, 1'b0, 32'd0, v);
    check(tag, v, exp);
  endtask

  // Returns the number of cycles (current one included) until irq is seen high.
  task automatic wait_irq(output int n);
    n = 1;
    while (!irq && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic clear_logs();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  initial begin
    int n, c0;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", 32'(m_cyc_o), 32'd0);
    check("rst_stb", 32'(m_stb_o), 32'd0);
    check("rst_adr", m_adr_o, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_wb_ack", 32'(wb_ack_o), 32'd0);
    check("sel_const", 32'(m_sel_o), 32'hF);
    @(negedge clk) rst = 1'b0;

    // Zero-wait copy of 4 words.
    wb_write(A_SRC, 32'h800);
    wb_write(A_DST, 32'hC00);
    wb_write(A_LEN, 32'd4);
    clear_logs();
    wb_write(A_CTRL, 32'h3);
    check("t1_first_stb", 32'(m_stb_o), 32'd1);
    check("t1_first_adr", m_adr_o, 32'h800);
    check("t1_first_we", 32'(m_we_o), 32'd0);
    wait_irq(n);
    check("t1_cycles", n, 32'd16);
    check("t1_nwrites", wa_q.size(), 32'd4);
    check("t1_nreads", rd_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size() && i < rd_q.size(); i++) begin
      check($sformatf("t1_rd_adr%0d", i), rd_q[i], 32'h800 + 32'(4 * i));
      check($sformatf("t1_wr_adr%0d", i), wa_q[i], 32'hC00 + 32'(4 * i));
      check($sformatf("t1_wr_dat%0d", i), wd_q[i], pat(32'h800 + 32'(4 * i)));
    end
    read_check("t1_status", A_STAT, 32'h0000_0002);
    check("t1_irq", 32'(irq), 32'd1);
    wb_write(A_STAT, 32'h2);
    check("t1_irq_clr", 32'(irq), 32'd0);

    // LEN==0: immediate DONE, no bus traffic; irq only with IEN.
    wb_write(A_LEN, 32'd0);
    c0 = cyc_cnt;
    wb_write(A_CTRL, 32'h1);
    check("t2_irq_noien", 32'(irq), 32'd0);
    read_check("t2_status", A_STAT, 32'h0000_0002);
    wb_write(A_STAT, 32'h2);
    wb_write(A_CTRL, 32'h3);
    check("t2_irq_ien", 32'(irq), 32'd1);
    check("t2_no_cyc", cyc_cnt, c0);
    wb_write(A_STAT, 32'h2);

    // Timeout with a slave that never acks.
    never_ack = 1'b1;
    wb_write(A_SRC, 32'h200);
    wb_write(A_DST, 32'h300);
    wb_write(A_LEN, 32'd3);
    wb_write(A_CTRL, 32'h3);
    n = 0;
    while (m_stb_o && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("t3_stb_cycles", n, TO);
    check("t3_cyc_low", 32'(m_cyc_o), 32'd0);
    check("t3_irq", 32'(irq), 32'd1);
    read_check("t3_status", A_STAT, 32'h0003_0004);
    read_check("t3_src_hold", A_SRC, 32'h200);
    wb_write(A_STAT, 32'h4);
    read_check("t3_status_clr", A_STAT, 32'h0003_0000);
    check("t3_irq_clr", 32'(irq), 32'd0);
    never_ack = 1'b0;

    // Writes during a transfer are ignored; remaining count reads live.
    wb_write(A_SRC, 32'h1000);
    wb_write(A_DST, 32'h2000);
    wb_write(A_LEN, 32'd8);
    clear_logs();
    wb_write(A_CTRL, 32'h3);
    n = 0;
    while (wa_q.size() < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    read_check("t4_status_mid", A_STAT, 32'h0005_0001);
    wb_write(A_LEN, 32'd1);
    wb_write(A_CTRL, 32'h3);
    wait_irq(n);
    check("t4_nwrites", wa_q.size(), 32'd8);
    if (wa_q.size() == 8) begin
      check("t4_last_adr", wa_q[7], 32'h201C);
      check("t4_last_dat", wd_q[7], pat(32'h101C));
    end
    read_check("t4_len_kept", A_LEN, 32'd8);
    read_check("t4_status_end", A_STAT, 32'h0000_0002);
    c0 = cyc_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_restart", cyc_cnt, c0);
    wb_write(A_STAT, 32'h2);

    // Address wrap and forced word alignment; unmapped offset.
    wb_write(A_SRC, 32'hFFFF_FFFC);
    wb_write(A_DST, 32'h103);
    read_check("t5_dst_align", A_DST, 32'h100);
    read_check("t5_unmapped", 32'h14, 32'd0);
    wb_write(A_LEN, 32'd2);
    clear_logs();
    wb_write(A_CTRL, 32'h3);
    wait_irq(n);
    check("t5_nreads", rd_q.size(), 32'd2);
    if (rd_q.size() == 2 && wa_q.size() == 2) begin
      check("t5_rd0", rd_q[0], 32'hFFFF_FFFC);
      check("t5_rd1", rd_q[1], 32'h0);
      check("t5_wa0", wa_q[0], 32'h100);
      check("t5_wa1", wa_q[1], 32'h104);
      check("t5_wd1", wd_q[1], pat(32'h0));
    end
    read_check("t5_src_end", A_SRC, 32'h4);
    read_check("t5_dst_end", A_DST, 32'h108);
    wb_write(A_STAT, 32'h2);

    // Async reset during a waited write strobe.
    wait_n = 3;
    wb_write(A_SRC, 32'h400);
    wb_write(A_DST, 32'h500);
    wb_write(A_LEN, 32'd2);
    wb_write(A_CTRL, 32'h3);
    n = 0;
    while (!(m_stb_o && m_we_o) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_in_wr", 32'(m_we_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_cyc_async", 32'(m_cyc_o), 32'd0);
    check("t6_stb_async", 32'(m_stb_o), 32'd0);
    @(negedge clk) rst = 1'b0;
    c0 = cyc_cnt;
    read_check("t6_src", A_SRC, 32'd0);
    read_check("t6_dst", A_DST, 32'd0);
    read_check("t6_len", A_LEN, 32'd0);
    read_check("t6_ctrl", A_CTRL, 32'd0);
    read_check("t6_status", A_STAT, 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_quiet", cyc_cnt, c0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
